// File: rtl/move_gen_sequencer_pkg.sv
// Shared definitions for the move-generation sequencer: mode codes, piece codes,
// FSM states and the pawn-promotion helper.
package move_gen_sequencer_pkg;

  localparam int unsigned ScoreW   = 8;
  localparam int unsigned NumDirs  = 16;
  localparam int unsigned CandLat  = 2;
  localparam int unsigned ColorBit = 5;
  localparam int unsigned LastSq   = 63;

  localparam logic [4:0] PieceEmpty  = 5'd0;
  localparam logic [4:0] PiecePawn   = 5'd1;
  localparam logic [4:0] PieceKnight = 5'd2;

  typedef enum logic [1:0] {
    ModeInit    = 2'b00,
    ModeQuiet   = 2'b01,
    ModeCapture = 2'b10,
    ModePromote = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StEmit,
    StDrain,
    StDone
  } state_e;

  // A pawn one step from the far rank promotes on its quiet pass.
  function automatic logic is_promote(input logic [4:0] ptype, input logic [5:0] pos,
                                      input logic color);
    logic [2:0] rank;
    rank = pos[5:3];
    return (ptype == PiecePawn) && (color ? (rank == 3'd1) : (rank == 3'd6));
  endfunction

endpackage

// File: rtl/move_gen_sequencer_if.sv
// Board-read, transmitter-drive and scored-candidate signals of the sequencer.
// master = sequencer side, slave = board memory / transmitter / scoring side.
interface move_gen_sequencer_if #(
  parameter int unsigned ScoreW = 8
);

  logic [5:0]        brd_addr;
  logic [5:0]        brd_piece;
  logic [1:0]        mode;
  logic              mask;
  logic [5:0]        piece_reg;
  logic [5:0]        pos_reg;
  logic [3:0]        dir_sel;
  logic              tx_valid;
  logic              cand_valid;
  logic [ScoreW-1:0] cand_score;
  logic [5:0]        cand_to;

  modport master (
    output brd_addr, mode, mask, piece_reg, pos_reg, dir_sel, tx_valid,
    input  brd_piece, cand_valid, cand_score, cand_to
  );

  modport slave (
    input  brd_addr, mode, mask, piece_reg, pos_reg, dir_sel, tx_valid,
    output brd_piece, cand_valid, cand_score, cand_to
  );

endinterface

// File: rtl/move_gen_sequencer_best_move_tracker.sv
// Registered running maximum over scored candidates; ties go to the newer one.
module best_move_tracker #(
  parameter int unsigned ScoreW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              upd_i,
  input  logic [ScoreW-1:0] score_i,
  input  logic [5:0]        from_i,
  input  logic [5:0]        to_i,
  output logic              valid_o,
  output logic [ScoreW-1:0] score_o,
  output logic [5:0]        from_o,
  output logic [5:0]        to_o
);

  logic              valid_q, valid_d;
  logic [ScoreW-1:0] score_q, score_d;
  logic [5:0]        from_q, from_d;
  logic [5:0]        to_q, to_d;

  always_comb begin
    valid_d = valid_q;
    score_d = score_q;
    from_d  = from_q;
    to_d    = to_q;
    if (clear_i) begin
      valid_d = 1'b0;
      score_d = '0;
      from_d  = '0;
      to_d    = '0;
    end else if (upd_i && (!valid_q || score_i >= score_q)) begin
      valid_d = 1'b1;
      score_d = score_i;
      from_d  = from_i;
      to_d    = to_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      score_q <= '0;
      from_q  <= '0;
      to_q    <= '0;
    end else begin
      valid_q <= valid_d;
      score_q <= score_d;
      from_q  <= from_d;
      to_q    <= to_d;
    end
  end

  assign valid_o = valid_q;
  assign score_o = score_q;
  assign from_o  = from_q;
  assign to_o    = to_q;

endmodule

// File: rtl/move_gen_sequencer.sv
// Scans the board, drives the transmitter through capture and quiet/promote passes for
// each engine-coloured piece, and keeps the best returned candidate.
module move_gen_sequencer
  import move_gen_sequencer_pkg::*;
#(
  parameter int unsigned ScoreW  = move_gen_sequencer_pkg::ScoreW,
  parameter int unsigned NumDirs = move_gen_sequencer_pkg::NumDirs,
  parameter int unsigned CandLat = move_gen_sequencer_pkg::CandLat
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        engine_color_i,
  move_gen_sequencer_if.master        tx_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        best_valid_o,
  output logic [ScoreW-1:0]           best_score_o,
  output logic [5:0]                  best_from_o,
  output logic [5:0]                  best_to_o
);

  localparam int unsigned DrainW = (CandLat > 1) ? $clog2(CandLat) : 1;

  state_e            state_q, state_d;
  logic [5:0]        sq_q, sq_d;
  logic [3:0]        dir_q, dir_d;
  logic              pass_q, pass_d;
  logic              color_q, color_d;
  logic [5:0]        piece_q, piece_d;
  logic [5:0]        pos_q, pos_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              clear_best;
  logic              emit;
  logic              own_piece;

  // Origin squares travel alongside tx_valid so late candidates get the right "from".
  logic [CandLat-1:0] org_vld_q;
  logic [5:0]         org_q [CandLat];
  logic [5:0]         cand_from;

  assign own_piece = (tx_if.brd_piece[4:0] != PieceEmpty) &&
                     (tx_if.brd_piece[ColorBit] == color_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sq_q    <= '0;
      dir_q   <= '0;
      pass_q  <= 1'b0;
      color_q <= 1'b0;
      piece_q <= '0;
      pos_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      dir_q   <= dir_d;
      pass_q  <= pass_d;
      color_q <= color_d;
      piece_q <= piece_d;
      pos_q   <= pos_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sq_d       = sq_q;
    dir_d      = dir_q;
    pass_d     = pass_q;
    color_d    = color_q;
    piece_d    = piece_q;
    pos_d      = pos_q;
    drain_d    = drain_q;
    clear_best = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StFetch;
          sq_d       = '0;
          color_d    = engine_color_i;
          clear_best = 1'b1;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (own_piece) begin
          state_d = StEmit;
          piece_d = tx_if.brd_piece;
          pos_d   = sq_q;
          dir_d   = '0;
          pass_d  = 1'b0;
        end else if (sq_q == 6'(LastSq)) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          state_d = StFetch;
          sq_d    = sq_q + 6'd1;
        end
      end
      StEmit: begin
        dir_d = dir_q + 4'd1;
        if (dir_q == 4'(NumDirs - 1)) begin
          dir_d  = '0;
          pass_d = ~pass_q;
          if (pass_q) begin
            if (sq_q == 6'(LastSq)) begin
              state_d = StDrain;
              drain_d = '0;
            end else begin
              state_d = StFetch;
              sq_d    = sq_q + 6'd1;
            end
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(CandLat - 1)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign emit = (state_q == StEmit);

  always_comb begin
    tx_if.tx_valid = 1'b0;
    tx_if.mode     = ModeInit;
    tx_if.mask     = 1'b0;
    tx_if.dir_sel  = '0;
    if (emit) begin
      tx_if.tx_valid = 1'b1;
      tx_if.dir_sel  = dir_q;
      tx_if.mask     = pass_q;
      if (!pass_q) begin
        tx_if.mode = ModeCapture;
      end else if (is_promote(piece_q[4:0], pos_q, color_q)) begin
        tx_if.mode = ModePromote;
      end else begin
        tx_if.mode = ModeQuiet;
      end
    end
  end

  assign tx_if.brd_addr  = sq_q;
  assign tx_if.piece_reg = piece_q;
  assign tx_if.pos_reg   = pos_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      org_vld_q <= '0;
      for (int k = 0; k < CandLat; k++) org_q[k] <= '0;
    end else begin
      org_vld_q[0] <= emit;
      org_q[0]     <= pos_q;
      for (int k = 1; k < CandLat; k++) begin
        org_vld_q[k] <= org_vld_q[k-1];
        org_q[k]     <= org_q[k-1];
      end
    end
  end

  // Newest emitting origin wins; with no recent emission fall back to the current piece.
  always_comb begin
    cand_from = pos_q;
    for (int k = CandLat - 1; k >= 0; k--) begin
      if (org_vld_q[k]) cand_from = org_q[k];
    end
  end

  best_move_tracker #(
    .ScoreW (ScoreW)
  ) u_best (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_best),
    .upd_i   (tx_if.cand_valid && busy_o),
    .score_i (tx_if.cand_score),
    .from_i  (cand_from),
    .to_i    (tx_if.cand_to),
    .valid_o (best_valid_o),
    .score_o (best_score_o),
    .from_o  (best_from_o),
    .to_o    (best_to_o)
  );

endmodule

// File: tb/tb_move_gen_sequencer.sv
// Scoreboard bench: stimulus queues expected transmitter beats and scan results,
// a negedge monitor pops and compares whenever the sequencer presents them.
module tb_move_gen_sequencer;
  import move_gen_sequencer_pkg::*;

  typedef struct {
    logic [1:0] mode;
    logic       mask;
    logic [3:0] dir;
    logic [5:0] pos;
    logic [5:0] piece;
  } beat_t;

  typedef struct {
    int         lat;
    logic       bv;
    logic [7:0] score;
    logic [5:0] from;
    logic [5:0] to;
  } done_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       engine_color_i = 1'b0;
  logic       busy, done, bv;
  logic [7:0] bs;
  logic [5:0] bf, bt;
  logic [5:0] board [64];

  int checks = 0, failures = 0, cyc = 0, start_cyc = 0, done_cnt = 0;
  beat_t tx_exp[$];
  done_t done_exp[$];
  beat_t mb;
  done_t md;

  move_gen_sequencer_if #(.ScoreW(8)) bus ();

  move_gen_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .engine_color_i (engine_color_i),
    .tx_if          (bus.master),
    .busy_o         (busy),
    .done_o         (done),
    .best_valid_o   (bv),
    .best_score_o   (bs),
    .best_from_o    (bf),
    .best_to_o      (bt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    bus.brd_piece <= board[bus.brd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: cycle number counts the first cycle after the start edge as 1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_valid) begin
        if (tx_exp.size() == 0) begin
          check("tx_unexpected", 32'd1, 32'd0);
        end else begin
          mb = tx_exp.pop_front();
          check("tx_beat", {bus.mode, bus.mask, bus.dir_sel, bus.pos_reg, bus.piece_reg},
                {mb.mode, mb.mask, mb.dir, mb.pos, mb.piece});
        end
      end
      if (done) begin
        done_cnt++;
        if (done_exp.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          md = done_exp.pop_front();
          check("done_cycle", cyc - start_cyc + 1, md.lat);
          check("best", {bv, bs, bf, bt}, {md.bv, md.score, md.from, md.to});
        end
      end
    end
  end

  task automatic push_piece(input logic [5:0] pos, input logic [5:0] piece, input logic prom);
    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < 16; d++) begin
        beat_t b;
        b.mode  = (p == 0) ? 2'b10 : (prom ? 2'b11 : 2'b01);
        b.mask  = (p == 1);
        b.dir   = 4'(d);
        b.pos   = pos;
        b.piece = piece;
        tx_exp.push_back(b);
      end
    end
  endtask

  task automatic push_done(input int lat, input logic v, input logic [7:0] s,
                           input logic [5:0] f, input logic [5:0] t);
    done_t e;
    e.lat = lat; e.bv = v; e.score = s; e.from = f; e.to = t;
    done_exp.push_back(e);
  endtask

  task automatic start_scan(input logic color);
    @(negedge clk);
    start_i = 1'b1;
    engine_color_i = color;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc - start_cyc + 1 < n) @(negedge clk);
  endtask

  task automatic cand_at(input int n, input logic [7:0] s, input logic [5:0] to);
    wait_cyc(n);
    bus.cand_valid = 1'b1;
    bus.cand_score = s;
    bus.cand_to    = to;
    @(negedge clk);
    bus.cand_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == n0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", done_cnt != n0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.cand_valid = 1'b0;
    bus.cand_score = '0;
    bus.cand_to    = '0;
    for (int i = 0; i < 64; i++) board[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.tx_valid, bus.mode, bus.mask, bus.dir_sel, busy, done, bv,
                            bus.brd_addr, bus.pos_reg}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty board: no beats, done in cycle 131.
    push_done(131, 1'b0, 8'd0, 6'd0, 6'd0);
    start_scan(1'b0);
    check("busy_after_start", busy, 32'd1);
    wait_done();

    // White knight at 1: 32 beats, ties go to the newer candidate, restart attempt ignored.
    board[1] = {1'b0, PieceKnight};
    push_piece(6'd1, {1'b0, PieceKnight}, 1'b0);
    push_done(163, 1'b1, 8'd9, 6'd1, 6'd30);
    start_scan(1'b0);
    cand_at(11, 8'd5, 6'd10);
    cand_at(21, 8'd9, 6'd20);
    cand_at(31, 8'd9, 6'd30);
    wait_cyc(51);
    start_i = 1'b1;
    engine_color_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    check("best_hold_after_done", {bv, bs, bt}, {1'b1, 8'd9, 6'd30});

    // White pawn at 52 promotes; a candidate in the last drain cycle still counts.
    board[1]  = '0;
    board[52] = {1'b0, PiecePawn};
    push_piece(6'd52, {1'b0, PiecePawn}, 1'b1);
    push_done(163, 1'b1, 8'd200, 6'd52, 6'd60);
    start_scan(1'b0);
    cand_at(121, 8'd100, 6'd44);
    cand_at(162, 8'd200, 6'd60);
    wait_done();

    // Black pawn with white to move is skipped; start clears the previous best.
    board[52] = {1'b1, PiecePawn};
    push_done(131, 1'b0, 8'd0, 6'd0, 6'd0);
    start_scan(1'b0);
    wait_done();

    // Reset in the middle of emission, then a clean rerun.
    board[52] = '0;
    board[1]  = {1'b0, PieceKnight};
    push_piece(6'd1, {1'b0, PieceKnight}, 1'b0);
    start_scan(1'b0);
    cand_at(9, 8'd77, 6'd5);
    wait_cyc(11);
    check("emit_before_reset", bus.tx_valid, 32'd1);
    #2 rst_n = 1'b0;
    tx_exp.delete();
    #1;
    check("reset_mid_emit", {bus.tx_valid, bus.mode, bus.mask, bus.dir_sel, busy, done, bv,
                             bus.brd_addr, bus.pos_reg, bus.piece_reg}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", done_cnt, 32'd4);
    push_piece(6'd1, {1'b0, PieceKnight}, 1'b0);
    push_done(163, 1'b0, 8'd0, 6'd0, 6'd0);
    start_scan(1'b0);
    wait_done();

    check("tx_queue_drained", tx_exp.size(), 32'd0);
    check("done_queue_drained", done_exp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
